// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the PC, issues single-word
//               reads to instruction memory (one outstanding at most), and
//               buffers returned words with their PCs in a small FIFO that
//               decode drains through a valid/ready handshake. Redirects
//               flush the buffer and discard any in-flight response.
//               Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect
//               raises fault_o and parks the unit in HALT until an aligned
//               redirect or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_data_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        fault_o
);

   localparam int                PTR_W    = $clog2(FIFO_DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic               discard_q, discard_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        fifo_instr_q [FIFO_DEPTH];
   logic [31:0]        fifo_instr_d [FIFO_DEPTH];
   logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]        fifo_pc_d    [FIFO_DEPTH];

   logic               push, pop, issue, flush;
   logic [31:0]        redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic               fault_q, fault_d;
   logic               misaligned;

   assign misaligned      = (redirect_pc_i[1:0] != 2'b00);
   assign redirect_target = redirect_pc_i;
   assign fault_o         = fault_q;
`else
   logic [1:0]         unused_redirect_lsbs;

   // Without the trap, the low address bits are simply forced to word alignment.
   assign unused_redirect_lsbs = redirect_pc_i[1:0];
   assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
   assign fault_o              = 1'b0;
`endif

   // Buffer head; outputs read as zero while the buffer is empty.
   assign valid_o     = (count_q != '0);
   assign instr_o     = valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0;
   assign pc_o        = valid_o ? fifo_pc_q[rd_ptr_q]    : 32'h0;
   assign pc_plus4_o  = pc_o + 32'd4;
   assign imem_addr_o = pc_q;

   // Next-state: redirect first, then response handling, issue, and FIFO bookkeeping.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      discard_d    = discard_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;
      imem_req_o   = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      issue        = 1'b0;
      flush        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d      = fault_q;
`endif

      if (redirect_i) begin
         flush = 1'b1;
         pc_d  = redirect_target;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (misaligned) begin
            state_d   = ST_HALT;
            fault_d   = 1'b1;
            discard_d = 1'b0;
         end else begin
            fault_d = 1'b0;
            if (state_q == ST_WAIT && !imem_valid_i) begin
               discard_d = 1'b1;
            end else begin
               state_d   = ST_IDLE;
               discard_d = 1'b0;
            end
         end
`else
         if (state_q == ST_WAIT && !imem_valid_i) begin
            discard_d = 1'b1;
         end else begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
         end
`endif
      end else begin
         pop = valid_o & ready_i;
         unique case (state_q)
            ST_IDLE: issue = enable_i && (count_q < DEPTH_C);
            ST_WAIT: begin
               if (imem_valid_i) begin
                  push      = !discard_q;
                  discard_d = 1'b0;
                  // Space check ignores a same-cycle pop so a push is never lost.
                  issue     = enable_i && (count_q < DEPTH_M1);
                  if (!issue) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end

      if (issue) begin
         imem_req_o = 1'b1;
         fetch_pc_d = pc_q;
         pc_d       = pc_q + 32'd4;
         state_d    = ST_WAIT;
      end

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            fifo_instr_d[wr_ptr_q] = imem_data_i;
            fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
            wr_ptr_d               = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         discard_q  <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q    <= fault_d;
`endif
      end
   end

   // Buffer storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk_i) begin
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a simple
//               fixed-latency instruction memory model (data = addr ^ KEY).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5C3_0F1E;

   logic        clk;
   logic        reset_i;
   logic        enable_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i;
   logic [31:0] imem_data_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        fault_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat      = 1;

   logic [31:0] req_q[$];
   logic [31:0] out_pc[$];
   logic [31:0] out_instr[$];
   logic [31:0] out_p4[$];

   logic        pend;
   int          pend_cnt;
   logic [31:0] pend_addr;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .enable_i      (enable_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_valid_i  (imem_valid_i),
      .imem_data_i   (imem_data_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .fault_o       (fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model and monitor: respond lat cycles after a request; log requests and accepted entries.
   initial begin
      imem_valid_i = 1'b0;
      imem_data_i  = 32'h0;
      pend         = 1'b0;
      pend_cnt     = 0;
      pend_addr    = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         imem_valid_i = 1'b0;
         if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt <= 0) begin
               imem_valid_i = 1'b1;
               imem_data_i  = pend_addr ^ KEY;
               pend         = 1'b0;
            end
         end
         @(negedge clk);
         if (imem_req_o) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = imem_addr_o;
            req_q.push_back(imem_addr_o);
         end
         if (valid_o && ready_i && !redirect_i && !reset_i) begin
            out_pc.push_back(pc_o);
            out_instr.push_back(instr_o);
            out_p4.push_back(pc_plus4_o);
         end
      end
   end

   // Hard stop so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end, need end of test");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic obs();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      req_q.delete();
      out_pc.delete();
      out_instr.delete();
      out_p4.delete();
   endtask

   task automatic collect(input int n, input int budget);
      for (int i = 0; i < budget && out_pc.size() < n; i++) begin
         tick();
         obs();
      end
   endtask

   task automatic do_reset();
      tick();
      reset_i    = 1'b1;
      enable_i   = 1'b0;
      redirect_i = 1'b0;
      ready_i    = 1'b0;
      repeat (5) tick();
      reset_i = 1'b0;
      obs();
      clear_logs();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", valid_o); end
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b need 0", imem_req_o); end
      n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b need 0", fault_o); end
      n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h need 0", instr_o); end
      n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h need 0", pc_o); end
      n_checks++; if (pc_plus4_o !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h need 4", pc_plus4_o); end
   endtask

   task automatic test_sequential();
      do_reset();
      lat = 1;
      tick();
      enable_i = 1'b1;
      ready_i  = 1'b1;
      obs();
      collect(6, 60);
      n_checks++; if (out_pc.size() !== 6) begin n_fail++; $display("FAIL seq_count: got %0d need 6", out_pc.size()); end
      for (int i = 0; i < out_pc.size() && i < 6; i++) begin
         n_checks++; if (out_pc[i] !== 32'(4*i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h need %h", i, out_pc[i], 32'(4*i)); end
         n_checks++; if (out_instr[i] !== (32'(4*i) ^ KEY)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h need %h", i, out_instr[i], 32'(4*i) ^ KEY); end
         n_checks++; if (out_p4[i] !== 32'(4*i + 4)) begin n_fail++; $display("FAIL seq_pc_plus4[%0d]: got %h need %h", i, out_p4[i], 32'(4*i + 4)); end
      end
      for (int i = 0; i < req_q.size() && i < 6; i++) begin
         n_checks++; if (req_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL seq_req[%0d]: got %h need %h", i, req_q[i], 32'(4*i)); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      lat = 1;
      tick();
      enable_i = 1'b1;
      ready_i  = 1'b0;
      obs();
      repeat (10) begin
         tick();
         obs();
      end
      n_checks++; if (req_q.size() !== 2) begin n_fail++; $display("FAIL bp_req_count: got %0d need 2", req_q.size()); end
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b need 1", valid_o); end
      n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h need 0", pc_o); end
      n_checks++; if (instr_o !== KEY) begin n_fail++; $display("FAIL bp_head_instr: got %h need %h", instr_o, KEY); end
      tick();
      ready_i = 1'b1;
      obs();
      collect(4, 40);
      n_checks++; if (out_pc.size() !== 4) begin n_fail++; $display("FAIL bp_out_count: got %0d need 4", out_pc.size()); end
      for (int i = 0; i < out_pc.size() && i < 4; i++) begin
         n_checks++; if (out_pc[i] !== 32'(4*i)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h need %h", i, out_pc[i], 32'(4*i)); end
      end
   endtask

   task automatic test_redirect_inflight();
      logic found;
      do_reset();
      lat = 3;
      tick();
      enable_i = 1'b1;
      ready_i  = 1'b1;
      obs();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (req_q.size() > 0 && req_q[$] == 32'h8) found = 1'b1;
         else begin
            tick();
            obs();
         end
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rdi_req8_seen: got %b need 1", found); end
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0100;
      obs();
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rdi_no_req_on_redirect: got %b need 0", imem_req_o); end
      clear_logs();
      tick();
      redirect_i = 1'b0;
      obs();
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rdi_flushed: got %b need 0", valid_o); end
      collect(2, 40);
      n_checks++; if (out_pc.size() !== 2) begin n_fail++; $display("FAIL rdi_out_count: got %0d need 2", out_pc.size()); end
      if (req_q.size() > 0) begin
         n_checks++; if (req_q[0] !== 32'h100) begin n_fail++; $display("FAIL rdi_first_req: got %h need 100", req_q[0]); end
      end
      if (out_pc.size() >= 2) begin
         n_checks++; if (out_pc[0] !== 32'h100) begin n_fail++; $display("FAIL rdi_first_pc: got %h need 100", out_pc[0]); end
         n_checks++; if (out_instr[0] !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL rdi_first_instr: got %h need %h", out_instr[0], 32'h100 ^ KEY); end
         n_checks++; if (out_pc[1] !== 32'h104) begin n_fail++; $display("FAIL rdi_second_pc: got %h need 104", out_pc[1]); end
      end
   endtask

   task automatic test_redirect_collide();
      logic found;
      do_reset();
      lat = 1;
      tick();
      enable_i = 1'b1;
      ready_i  = 1'b1;
      obs();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (imem_valid_i && valid_o) begin
            found         = 1'b1;
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_0040;
         end
         obs();
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rdc_collision_seen: got %b need 1", found); end
      n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rdc_no_req_on_redirect: got %b need 0", imem_req_o); end
      clear_logs();
      tick();
      redirect_i = 1'b0;
      obs();
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rdc_empty: got %b need 0", valid_o); end
      n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rdc_req: got %b need 1", imem_req_o); end
      n_checks++; if (imem_addr_o !== 32'h40) begin n_fail++; $display("FAIL rdc_addr: got %h need 40", imem_addr_o); end
      collect(1, 20);
      n_checks++; if (out_pc.size() < 1 || out_pc[0] !== 32'h40) begin n_fail++; $display("FAIL rdc_first_pc: got %h need 40", out_pc.size() > 0 ? out_pc[0] : 32'hX); end
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 2;
      tick();
      ready_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      obs();
      tick();
      redirect_i = 1'b0;
      enable_i   = 1'b1;
      obs();
      collect(2, 30);
      n_checks++; if (out_pc.size() !== 2) begin n_fail++; $display("FAIL wrap_out_count: got %0d need 2", out_pc.size()); end
      if (req_q.size() >= 2) begin
         n_checks++; if (req_q[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got %h need fffffffc", req_q[0]); end
         n_checks++; if (req_q[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_req1: got %h need 0", req_q[1]); end
      end
      if (out_pc.size() >= 2) begin
         n_checks++; if (out_pc[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h need fffffffc", out_pc[0]); end
         n_checks++; if (out_p4[0] !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4_0: got %h need 0", out_p4[0]); end
         n_checks++; if (out_instr[0] !== (32'hFFFF_FFFC ^ KEY)) begin n_fail++; $display("FAIL wrap_instr0: got %h need %h", out_instr[0], 32'hFFFF_FFFC ^ KEY); end
         n_checks++; if (out_pc[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_pc1: got %h need 0", out_pc[1]); end
         n_checks++; if (out_p4[1] !== 32'h4) begin n_fail++; $display("FAIL wrap_pc_plus4_1: got %h need 4", out_p4[1]); end
      end
   endtask

   task automatic test_misalign();
      do_reset();
      lat = 1;
      tick();
      ready_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0102;
      obs();
      tick();
      redirect_i = 1'b0;
      enable_i   = 1'b1;
      obs();
`ifdef FETCH_MISALIGN_TRAP_EN
      n_checks++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL mis_fault_set: got %b need 1", fault_o); end
      repeat (20) begin
         tick();
         obs();
      end
      n_checks++; if (req_q.size() !== 0) begin n_fail++; $display("FAIL mis_halt_reqs: got %0d need 0", req_q.size()); end
      n_checks++; if (fault_o !== 1'b1) begin n_fail++; $display("FAIL mis_fault_held: got %b need 1", fault_o); end
      tick();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      obs();
      clear_logs();
      tick();
      redirect_i = 1'b0;
      obs();
      n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL mis_fault_clear: got %b need 0", fault_o); end
      collect(1, 20);
      n_checks++; if (out_pc.size() < 1 || out_pc[0] !== 32'h200) begin n_fail++; $display("FAIL mis_resume_pc: got %h need 200", out_pc.size() > 0 ? out_pc[0] : 32'hX); end
      n_checks++; if (req_q.size() < 1 || req_q[0] !== 32'h200) begin n_fail++; $display("FAIL mis_resume_req: got %h need 200", req_q.size() > 0 ? req_q[0] : 32'hX); end
`else
      n_checks++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL mis_fault_tied: got %b need 0", fault_o); end
      collect(2, 30);
      n_checks++; if (req_q.size() < 1 || req_q[0] !== 32'h100) begin n_fail++; $display("FAIL mis_aligned_req: got %h need 100", req_q.size() > 0 ? req_q[0] : 32'hX); end
      n_checks++; if (out_pc.size() < 2 || out_pc[0] !== 32'h100 || out_pc[1] !== 32'h104) begin
         n_fail++;
         $display("FAIL mis_aligned_pcs: got %0d entries, first %h, need 100 then 104", out_pc.size(), out_pc.size() > 0 ? out_pc[0] : 32'hX);
      end
`endif
   endtask

   initial begin
      reset_i       = 1'b1;
      enable_i      = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      ready_i       = 1'b0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_collide();
      test_wrap();
      test_misalign();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
